// File: rtl/rom_burst_reader.sv
// rom_burst_reader: sequential read front-end for the 16x16 one-hot lookup ROM.
// It walks the ROM address bus one word per cycle from StartAddr for Len+1 words.
// Each word is captured into an output register and streamed downstream over a
// valid/ready handshake that supports backpressure.
// Optional feature macro: ROM_BURST_ONEHOT_CHECK_EN. When it is defined, every
// captured word is encoded to the index of its highest set bit and checked for
// one-hotness; the error flag is sticky.
module rom_burst_reader #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic [AW-1:0] Len,
  output logic [AW-1:0] Addr,
  input  logic [DW-1:0] RomData,
  output logic [DW-1:0] OutData,
  output logic [AW-1:0] OutAddr,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          OutLast,
  output logic [AW-1:0] OutIndex,
  output logic          OneHotErr,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          slot_free;

  // The output register can take a new word when it is empty or its word is
  // leaving on this edge.
  assign slot_free = !out_valid_q || OutReady;

`ifdef ROM_BURST_ONEHOT_CHECK_EN
  localparam int PW = $clog2(DW + 1);

  logic [AW-1:0] out_index_q, out_index_d;
  logic          one_hot_err_q, one_hot_err_d;
  logic [AW-1:0] hi_index;
  logic [PW-1:0] pop_count;

  // Priority encoder (highest set bit wins) and popcount of the ROM word.
  always_comb begin
    hi_index  = '0;
    pop_count = '0;
    for (int i = 0; i < DW; i++) begin
      if (RomData[i]) begin
        hi_index = AW'(i);
      end
      pop_count = pop_count + PW'(RomData[i]);
    end
  end
`endif

  // Next-state logic for the burst FSM and every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef ROM_BURST_ONEHOT_CHECK_EN
    out_index_d   = out_index_q;
    one_hot_err_d = one_hot_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          addr_d      = StartAddr;
          remaining_d = Len;
          state_d     = RUN;
`ifdef ROM_BURST_ONEHOT_CHECK_EN
          one_hot_err_d = 1'b0;
`endif
        end
      end

      RUN: begin
        if (slot_free) begin
          out_data_d  = RomData;
          out_addr_d  = addr_q;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == '0);
`ifdef ROM_BURST_ONEHOT_CHECK_EN
          out_index_d   = hi_index;
          one_hot_err_d = one_hot_err_q || (pop_count != PW'(1));
`endif
          if (remaining_q == '0) begin
            state_d = FINISH;
          end else begin
            addr_d      = addr_q + AW'(1);
            remaining_d = remaining_q - AW'(1);
          end
        end
      end

      FINISH: begin
        if (out_valid_q && OutReady) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROM_BURST_ONEHOT_CHECK_EN
      out_index_q   <= '0;
      one_hot_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ROM_BURST_ONEHOT_CHECK_EN
      out_index_q   <= out_index_d;
      one_hot_err_q <= one_hot_err_d;
`endif
    end
  end

  assign Addr     = addr_q;
  assign OutData  = out_data_q;
  assign OutAddr  = out_addr_q;
  assign OutValid = out_valid_q;
  assign OutLast  = out_last_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

`ifdef ROM_BURST_ONEHOT_CHECK_EN
  assign OutIndex  = out_index_q;
  assign OneHotErr = one_hot_err_q;
`else
  assign OutIndex  = '0;
  assign OneHotErr = 1'b0;
`endif

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Sequential read front-end for the 16x16 one-hot lookup ROM. Accepts a start address and burst length, drives the ROM address bus one word per cycle, captures the combinational ROM data into an output register, and streams the words downstream over a valid/ready handshake with backpressure. Sits directly upstream of the ROM (address side) and downstream of it (data side), between the ROM and the consuming datapath.

## Interface
- AW, 4, ROM address width (16 words)
- DW, 16, ROM data width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- Start  in  1  burst request; sampled only in IDLE
- StartAddr  in  AW  first address of burst
- Len  in  AW  burst length minus one (0 → 1 word, 15 → 16 words)
- Addr  out  AW  registered address to ROM
- RomData  in  DW  combinational data from ROM for Addr
- OutData  out  DW  captured word
- OutAddr  out  AW  address OutData was read from
- OutValid  out  1  OutData valid
- OutReady  in  1  consumer accepts word
- OutLast  out  1  OutData is final word of burst
- OutIndex  out  AW  bit position of the set bit in OutData
- OneHotErr  out  1  sticky: a captured word was not one-hot
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse after final word handshakes

## Operation
- Reset values: Addr=0, OutData=0, OutAddr=0, OutValid=0, OutLast=0, OutIndex=0, OneHotErr=0, Busy=0, Done=0; state IDLE.
- States: IDLE, RUN, FINISH. Busy=1 in RUN and FINISH.
- IDLE: Start=1 → Addr<=StartAddr, Remaining<=Len, OneHotErr<=0, state RUN. Start=0 → hold.
- RUN: capture when slot free (OutValid=0 or OutReady=1): OutData<=RomData, OutAddr<=Addr, OutValid<=1, OutLast<=(Remaining==0). If Remaining==0 → FINISH; else Addr<=Addr+1, Remaining<=Remaining-1. Slot not free → hold all.
- Address wraps 15→0 (modulo 2^AW); wrapped burst is legal.
- FINISH: OutValid=1 and OutReady=1 → OutValid<=0, OutLast<=0, Done<=1 for one cycle, state IDLE.
- Start while Busy ignored; no queuing. Start same cycle as Done pulse is accepted (state already IDLE).
- Handshake: word transfers on a cycle with OutValid=1 and OutReady=1. Once asserted, OutValid holds and OutData/OutAddr/OutLast stay stable until transfer.
- rst mid-burst: all outputs to reset values immediately; in-flight word discarded, no Done.

## Timing
- Start sampled at edge N → Addr=StartAddr from N; first OutValid=1 after edge N+1.
- Throughput 1 word/cycle with OutReady held high; burst of L+1 words: last word valid after edge N+L+1, Done high after the edge on which the last word transfers.
- OutReady low stalls Addr and capture with zero word loss; no combinational path OutReady→OutValid.
- RomData must settle within one cycle of Addr change (combinational ROM).

## Configuration
- ROM_BURST_ONEHOT_CHECK_EN defined: on each capture OutIndex<=position of highest set bit of RomData (0 if RomData==0); OneHotErr sets if popcount(RomData)!=1, stays set until next accepted Start or rst.
- Undefined: OutIndex and OneHotErr tied to 0; no encoder/popcount logic.

## Test plan
- Reset then Start, StartAddr=0, Len=15, OutReady=1 → 16 words 0x0001…0x8000 on consecutive cycles, OutAddr 0…15, OutLast on 16th, Done one cycle later, Busy low with Done.
- StartAddr=14, Len=3 → OutAddr 14,15,0,1, OutData 0x4000,0x8000,0x0001,0x0002, OutLast on 0x0002.
- StartAddr=4, Len=2, OutReady toggled 1,0,0,1,0,1 → exactly 0x0010,0x0020,0x0040 delivered once each, OutData stable during stalls.
- Start pulsed during burst (StartAddr=9) → ignored, original burst completes unchanged; Start on Done cycle → new burst starts.
- rst asserted mid-burst after 3 words → OutValid=0, Busy=0, Done never pulses, Addr=0.
- With ROM_BURST_ONEHOT_CHECK_EN, ROM word forced 0x0003 at Addr 5 → OutIndex=1, OneHotErr=1 sticky; clean words give OutIndex=Addr; next Start clears error.
